// File: rtl/cpu_test_sequencer_if.sv
// cpu_test_sequencer_if: control, ROM, instruction-memory, debug and status signals of the CPU self-test harness
interface cpu_test_sequencer_if #(
   parameter int ADDR_WIDTH    = 8,
   parameter int DATA_WIDTH    = 16,
   parameter int REG_SEL_WIDTH = 3,
   parameter int CNT_WIDTH     = 16
);
   logic                     start;
   logic [ADDR_WIDTH:0]      prog_len;
   logic [REG_SEL_WIDTH-1:0] check_reg;
   logic [DATA_WIDTH-1:0]    expected;
   logic [ADDR_WIDTH-1:0]    rom_addr;
   logic [DATA_WIDTH-1:0]    rom_data;
   logic                     imem_we;
   logic [ADDR_WIDTH-1:0]    imem_addr;
   logic [DATA_WIDTH-1:0]    imem_wdata;
   logic                     cpu_rst;
   logic                     cpu_halt;
   logic [REG_SEL_WIDTH-1:0] dbg_addr;
   logic [DATA_WIDTH-1:0]    dbg_data;
   logic                     busy;
   logic                     done;
   logic                     pass;
   logic                     timeout;
   logic [CNT_WIDTH-1:0]     cycle_count;
   modport master (
      output start, prog_len, check_reg, expected, rom_data, cpu_halt, dbg_data,
      input  rom_addr, imem_we, imem_addr, imem_wdata, cpu_rst, dbg_addr,
             busy, done, pass, timeout, cycle_count
   );
   modport slave (
      input  start, prog_len, check_reg, expected, rom_data, cpu_halt, dbg_data,
      output rom_addr, imem_we, imem_addr, imem_wdata, cpu_rst, dbg_addr,
             busy, done, pass, timeout, cycle_count
   );
endinterface

// File: rtl/cpu_test_sequencer.sv
// cpu_test_sequencer: loads a program into the CPU, runs it to halt or timeout, then checks one register
module cpu_test_sequencer #(
   parameter int ADDR_WIDTH     = 8,
   parameter int DATA_WIDTH     = 16,
   parameter int REG_SEL_WIDTH  = 3,
   parameter int CNT_WIDTH      = 16,
   parameter int TIMEOUT_CYCLES = 1000
) (
   input logic                clk,
   input logic                rst,
   cpu_test_sequencer_if.slave bus
);
   typedef enum logic [2:0] {IDLE, LOAD, RUN, CHK_RD, CHK_CMP, DONE} state_t;
   state_t                   state, state_nxt;
   logic [ADDR_WIDTH:0]      idx, len;
   logic [REG_SEL_WIDTH-1:0] reg_q;
   logic [DATA_WIDTH-1:0]    exp_q;
   logic                     pass_q, timeout_q, accept, run_last, we;
   logic [CNT_WIDTH-1:0]     cnt, cnt_inc;
   assign cnt_inc  = cnt + 1'b1;
   assign accept   = bus.start && (state == IDLE || state == DONE);
   assign run_last = cnt_inc == CNT_WIDTH'(TIMEOUT_CYCLES);
   // state register
   always_ff @(posedge clk or posedge rst)
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   // next-state: LOAD runs len+1 cycles because ROM data trails its address by one cycle
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE, DONE: state_nxt = accept ? LOAD : state;
         LOAD:       state_nxt = (idx == len) ? RUN : LOAD;
         RUN:        state_nxt = bus.cpu_halt ? CHK_RD : (run_last ? DONE : RUN);
         CHK_RD:     state_nxt = CHK_CMP;
         CHK_CMP:    state_nxt = DONE;
         default:    state_nxt = IDLE;
      endcase
   end
   // test parameters, load index, cycle counter and result flags; halt beats timeout in the same cycle
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         idx       <= '0;
         len       <= '0;
         reg_q     <= '0;
         exp_q     <= '0;
         pass_q    <= 1'b0;
         timeout_q <= 1'b0;
         cnt       <= '0;
      end else begin
         if (accept) begin
            len       <= bus.prog_len[ADDR_WIDTH] ? {1'b1, {ADDR_WIDTH{1'b0}}} : bus.prog_len;
            reg_q     <= bus.check_reg;
            exp_q     <= bus.expected;
            pass_q    <= 1'b0;
            timeout_q <= 1'b0;
            cnt       <= '0;
            idx       <= '0;
         end
         if (state == LOAD) idx <= idx + 1'b1;
         if (state == RUN) begin
            cnt <= cnt_inc;
            if (!bus.cpu_halt && run_last) timeout_q <= 1'b1;
         end
         if (state == CHK_CMP) pass_q <= bus.dbg_data == exp_q;
      end
   assign we              = state == LOAD && idx != '0;
   assign bus.imem_we     = we;
   assign bus.imem_addr   = we ? ADDR_WIDTH'(idx - 1'b1) : '0;
   assign bus.imem_wdata  = we ? bus.rom_data : '0;
   assign bus.rom_addr    = (state == LOAD && idx < len) ? idx[ADDR_WIDTH-1:0] : '0;
   assign bus.cpu_rst     = !(state == RUN || state == CHK_RD || state == CHK_CMP);
   assign bus.dbg_addr    = state == CHK_RD ? reg_q : '0;
   assign bus.busy        = state == LOAD || state == RUN || state == CHK_RD || state == CHK_CMP;
   assign bus.done        = state == DONE;
   assign bus.pass        = pass_q;
   assign bus.timeout     = timeout_q;
   assign bus.cycle_count = cnt;
endmodule

// File: tb/tb_cpu_test_sequencer.sv
// tb_cpu_test_sequencer: vector table plus write scoreboard for the CPU self-test harness
module tb_cpu_test_sequencer;
   typedef struct {
      logic [8:0]  prog_len;
      logic [2:0]  check_reg;
      logic [15:0] expected;
      logic [15:0] dbg_val;
      int          halt_at;
      bit          poke;
      bit          exp_pass;
      bit          exp_to;
      int          exp_cnt;
      int          exp_low;
   } vec_t;
   typedef struct packed {
      logic [7:0]  a;
      logic [15:0] d;
   } wr_t;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int checks = 0;
   int errors = 0;
   int halt_at = 0;
   int run_n = 0;
   logic [2:0]  chk_sel = '0;
   logic [15:0] dbg_val = '0;
   logic [15:0] rom [256];
   wr_t exp_q [$];
   vec_t vecs [7];
   cpu_test_sequencer_if #(.ADDR_WIDTH(8), .DATA_WIDTH(16), .REG_SEL_WIDTH(3), .CNT_WIDTH(16)) sif ();
   cpu_test_sequencer #(.ADDR_WIDTH(8), .DATA_WIDTH(16), .REG_SEL_WIDTH(3), .CNT_WIDTH(16), .TIMEOUT_CYCLES(20)) dut (
      .clk(clk),
      .rst(rst),
      .bus(sif.slave)
   );
   always #5 clk = ~clk;
   always @(posedge clk) sif.rom_data <= rom[sif.rom_addr];
   always @(posedge clk) sif.dbg_data <= (sif.dbg_addr == chk_sel) ? dbg_val : 16'hDEAD;
   always @(posedge clk) run_n <= sif.cpu_rst ? 0 : run_n + 1;
   assign sif.cpu_halt = !sif.cpu_rst && halt_at != 0 && run_n >= halt_at - 1;
   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask
   always @(negedge clk)
      if (sif.imem_we) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL extra_write actual=addr %0h required=no write", sif.imem_addr);
         end else begin
            wr_t w;
            w = exp_q.pop_front();
            if (sif.imem_addr != w.a || sif.imem_wdata != w.d) begin
               errors++;
               $display("FAIL imem_write actual=%0h:%0h required=%0h:%0h", sif.imem_addr, sif.imem_wdata, w.a, w.d);
            end
         end
      end
   task automatic run_vec(input vec_t v);
      int n, cyc, first_low, low_n;
      n = v.prog_len > 256 ? 256 : int'(v.prog_len);
      sif.prog_len  = v.prog_len;
      sif.check_reg = v.check_reg;
      sif.expected  = v.expected;
      chk_sel = v.check_reg;
      dbg_val = v.dbg_val;
      halt_at = v.halt_at;
      for (int i = 0; i < n; i++) exp_q.push_back({8'(i), rom[i]});
      sif.start = 1'b1;
      @(negedge clk);
      sif.start = 1'b0;
      chk("busy_load", sif.busy, 1);
      chk("done_drop", sif.done, 0);
      cyc = 1;
      first_low = -1;
      low_n = 0;
      while (!sif.done && cyc < 2000) begin
         if (!sif.cpu_rst) begin
            if (first_low < 0) first_low = cyc;
            low_n++;
            chk("busy_run", sif.busy, 1);
         end
         sif.start = v.poke && cyc == n + 4;
         @(negedge clk);
         cyc++;
      end
      sif.start = 1'b0;
      chk("done", sif.done, 1);
      chk("run_start", first_low, n + 2);
      chk("cpu_rst_low", low_n, v.exp_low);
      chk("pass", sif.pass, v.exp_pass);
      chk("timeout", sif.timeout, v.exp_to);
      chk("cycle_count", sif.cycle_count, v.exp_cnt);
      chk("cpu_rst_done", sif.cpu_rst, 1);
      chk("writes_left", exp_q.size(), 0);
      @(negedge clk);
      chk("pass_hold", sif.pass, v.exp_pass);
      chk("count_hold", sif.cycle_count, v.exp_cnt);
   endtask
   initial begin
      for (int i = 0; i < 256; i++) rom[i] = (i < 4) ? 16'(16'h1111 * (i + 1)) : 16'(i * 257 + 3);
      vecs[0] = '{9'd4,   3'd2, 16'h00AB, 16'h00AB, 10, 1'b0, 1'b1, 1'b0, 10, 12};
      vecs[1] = '{9'd4,   3'd2, 16'h00AB, 16'h00AA, 10, 1'b0, 1'b0, 1'b0, 10, 12};
      vecs[2] = '{9'd4,   3'd2, 16'h00AB, 16'h00AB, 0,  1'b0, 1'b0, 1'b1, 20, 20};
      vecs[3] = '{9'd0,   3'd1, 16'h0042, 16'h0042, 3,  1'b0, 1'b1, 1'b0, 3,  5};
      vecs[4] = '{9'd300, 3'd7, 16'hBEEF, 16'hBEEF, 1,  1'b0, 1'b1, 1'b0, 1,  3};
      vecs[5] = '{9'd4,   3'd3, 16'h5A5A, 16'h5A5A, 20, 1'b0, 1'b1, 1'b0, 20, 22};
      vecs[6] = '{9'd1,   3'd5, 16'h1234, 16'h1234, 10, 1'b1, 1'b1, 1'b0, 10, 12};
      sif.start = 1'b0;
      sif.prog_len = '0;
      sif.check_reg = '0;
      sif.expected = '0;
      #3;
      chk("rst_cpu_rst", sif.cpu_rst, 1);
      chk("rst_busy", sif.busy, 0);
      chk("rst_done", sif.done, 0);
      chk("rst_we", sif.imem_we, 0);
      chk("rst_count", sif.cycle_count, 0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (3) begin
         @(negedge clk);
         chk("idle_busy", sif.busy, 0);
         chk("idle_cpu_rst", sif.cpu_rst, 1);
      end
      foreach (vecs[i]) run_vec(vecs[i]);
      sif.prog_len = 9'd4;
      halt_at = 10;
      for (int i = 0; i < 4; i++) exp_q.push_back({8'(i), rom[i]});
      sif.start = 1'b1;
      @(negedge clk);
      sif.start = 1'b0;
      @(negedge clk);
      chk("mid_load_we", sif.imem_we, 1);
      #2 rst = 1'b1;
      #1;
      chk("abort_we", sif.imem_we, 0);
      chk("abort_busy", sif.busy, 0);
      chk("abort_cpu_rst", sif.cpu_rst, 1);
      chk("abort_rom_addr", sif.rom_addr, 0);
      chk("abort_count", sif.cycle_count, 0);
      exp_q.delete();
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      run_vec(vecs[0]);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
